// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package riscv_mem_pkg;

  localparam int WORD_W        = 32;
  localparam int DEPTH_DEFAULT = 16;

  // Which port owns the response that returns in the following cycle.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/mem_grant_sel.sv
// Fetch/data grant selection. The data port wins a conflict unless it has
// already taken MAX_DSTREAK grants in a row while fetch was waiting.
module mem_grant_sel #(
  parameter int MAX_DSTREAK = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic if_valid_i,
  input  logic d_valid_i,
  output logic if_grant_o,
  output logic d_grant_o
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          streak_full;

  assign streak_full = (streak_q == SW'(MAX_DSTREAK));

  // Grant decision: data by default, fetch once the streak limit is reached.
  always_comb begin
    d_grant_o  = d_valid_i && !(if_valid_i && streak_full);
    if_grant_o = if_valid_i && !d_grant_o;
  end

  // Streak counts data grants only while fetch is waiting.
  always_comb begin
    streak_d = streak_q;
    if (!if_valid_i || if_grant_o) begin
      streak_d = '0;
    end else if (d_grant_o) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // Streak counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch + data) arbiter onto a single-ported word memory with
// one-cycle read latency. Responses return exactly one cycle after issue.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int MAX_DSTREAK = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [WORD_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [WORD_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              d_req_valid,
  input  logic              d_req_we,
  input  logic [WORD_W-1:0] d_req_addr,
  input  logic [WORD_W-1:0] d_req_wdata,
  output logic              d_req_ready,
  output logic              d_rsp_valid,
  output logic [WORD_W-1:0] d_rsp_data,
  output logic              d_rsp_err,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  // Requests are masked while in reset so ready and strobes stay low.
  logic if_v, d_v, if_gnt, d_gnt;

  assign if_v = rst_n & if_req_valid;
  assign d_v  = rst_n & d_req_valid;

  mem_grant_sel #(
    .MAX_DSTREAK (MAX_DSTREAK)
  ) u_grant_sel (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_valid_i (if_v),
    .d_valid_i  (d_v),
    .if_grant_o (if_gnt),
    .d_grant_o  (d_gnt)
  );

  logic              issue, iss_we, iss_in_range;
  logic [WORD_W-1:0] iss_addr;

  rsp_state_e rsp_q, rsp_d;
  logic       err_q, err_d;
  logic       rd_q, rd_d;

  // Mux the granted request onto the issue path.
  always_comb begin
    issue        = if_gnt | d_gnt;
    iss_we       = d_gnt & d_req_we;
    iss_addr     = if_gnt ? if_req_addr : (d_gnt ? d_req_addr : '0);
    iss_in_range = (iss_addr < WORD_W'(DEPTH));
  end

  // Response state register; a pending response is dropped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= RSP_NONE;
      err_q <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      rsp_q <= rsp_d;
      err_q <= err_d;
      rd_q  <= rd_d;
    end
  end

  // Next response owner is taken from this cycle's issue.
  always_comb begin
    rsp_d = RSP_NONE;
    if (if_gnt) begin
      rsp_d = RSP_IF;
    end else if (d_gnt) begin
      rsp_d = RSP_D;
    end
    err_d = issue & ~iss_in_range;
    rd_d  = issue & iss_in_range & ~iss_we;
  end

  // Outputs: ready, memory strobes and routed responses.
  always_comb begin
    if_req_ready = if_gnt;
    d_req_ready  = d_gnt;
    mem_addr     = iss_addr;
    mem_rd       = issue & iss_in_range & ~iss_we;
    mem_wr       = issue & iss_in_range & iss_we;
    mem_wdata    = mem_wr ? d_req_wdata : '0;
    if_rsp_valid = (rsp_q == RSP_IF);
    d_rsp_valid  = (rsp_q == RSP_D);
    if_rsp_err   = if_rsp_valid & err_q;
    d_rsp_err    = d_rsp_valid & err_q;
    if_rsp_data  = (if_rsp_valid && rd_q) ? mem_rdata : '0;
    d_rsp_data   = (d_rsp_valid && rd_q) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a one-cycle-latency memory model.
module tb_mem_arbiter;
  import riscv_mem_pkg::*;

  localparam int DEPTH = 16;
  localparam int MAXS  = 2;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_err;
  logic [31:0] if_req_addr, if_rsp_data;
  logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid, d_rsp_err;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [31:0]   bd_data;
  logic [31:0]   mem_arr [DEPTH];
  logic [31:0]   ref_mem [DEPTH];

  int checks = 0;
  int failures = 0;

  logic [135:0] all_outs;
  assign all_outs = {if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
                     d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
                     mem_addr, mem_rd, mem_wr, mem_wdata};

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(DEPTH), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data), .if_rsp_err(if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory: synchronous write, read data one cycle after mem_rd, junk otherwise.
  always @(posedge clk) begin
    if (bd_we) mem_arr[bd_addr] <= bd_data;
    if (mem_wr) mem_arr[mem_addr[AW-1:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem_arr[mem_addr[AW-1:0]];
    else        mem_rdata <= $urandom;
  end

  task automatic drive_idle();
    if_req_valid = 1'b0; if_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0; d_req_wdata = '0;
  endtask

  task automatic settle();
    drive_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if_req_valid = 1'b1; if_req_addr = 32'd1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'd2; d_req_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (all_outs !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs);
    end
    #2;
    checks++;
    if (all_outs !== '0) begin
      failures++; $display("FAIL reset_outputs_offedge got=%h exp=0", all_outs);
    end
    drive_idle();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({if_rsp_valid, d_rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL reset_no_rsp got=%b exp=00", {if_rsp_valid, d_rsp_valid});
    end
  endtask

  task automatic test_fetch_single();
    if_req_valid = 1'b1; if_req_addr = 32'd3;
    @(negedge clk);
    checks++;
    if ({if_req_ready, d_req_ready, mem_rd, mem_wr, mem_addr} !== {4'b1010, 32'd3}) begin
      failures++;
      $display("FAIL fetch_issue got=%b%b%b%b addr=%0d exp=1010 addr=3",
               if_req_ready, d_req_ready, mem_rd, mem_wr, mem_addr);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rsp_valid, if_rsp_err, d_rsp_valid, if_rsp_data} !== {3'b100, 32'h6661c213}) begin
      failures++;
      $display("FAIL fetch_rsp got v=%b e=%b dv=%b data=%h exp v=1 e=0 dv=0 data=6661c213",
               if_rsp_valid, if_rsp_err, d_rsp_valid, if_rsp_data);
    end
    @(negedge clk);
    checks++;
    if ({if_rsp_valid, if_rsp_data} !== 33'd0) begin
      failures++; $display("FAIL fetch_single_pulse got v=%b data=%h exp 0", if_rsp_valid, if_rsp_data);
    end
    settle();
  endtask

  task automatic test_conflict();
    logic exp_d [6];
    logic prev_if, prev_d;
    exp_d = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    prev_if = 1'b0; prev_d = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'd1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({d_req_ready, if_req_ready} !== {exp_d[i], ~exp_d[i]}) begin
        failures++;
        $display("FAIL conflict_grant cyc=%0d got d=%b if=%b exp d=%b if=%b",
                 i, d_req_ready, if_req_ready, exp_d[i], ~exp_d[i]);
      end
      checks++;
      if ({if_rsp_valid, d_rsp_valid} !== {prev_if, prev_d}) begin
        failures++;
        $display("FAIL conflict_rsp_route cyc=%0d got if=%b d=%b exp if=%b d=%b",
                 i, if_rsp_valid, d_rsp_valid, prev_if, prev_d);
      end
      prev_if = ~exp_d[i]; prev_d = exp_d[i];
      @(posedge clk); #1;
      if (exp_d[i]) d_req_addr = 32'(i + 1);
      else          if_req_addr = 32'(i + 7);
    end
    settle();
  endtask

  task automatic test_back_to_back();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'd5; d_req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({d_req_ready, mem_wr, mem_rd, mem_addr, mem_wdata} !== {3'b110, 32'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL b2b_write_issue got rdy=%b wr=%b rd=%b addr=%0d wdata=%h",
               d_req_ready, mem_wr, mem_rd, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    d_req_we = 1'b0; d_req_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data, d_req_ready, mem_rd} !== {2'b10, 32'd0, 2'b11}) begin
      failures++;
      $display("FAIL b2b_write_ack got v=%b e=%b data=%h rdy=%b rd=%b exp v=1 e=0 data=0 rdy=1 rd=1",
               d_rsp_valid, d_rsp_err, d_rsp_data, d_req_ready, mem_rd);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    ref_mem[5] = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {2'b10, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL b2b_read_back got v=%b e=%b data=%h exp v=1 e=0 data=deadbeef",
               d_rsp_valid, d_rsp_err, d_rsp_data);
    end
    settle();
  endtask

  task automatic test_out_of_range();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd16;
    @(negedge clk);
    checks++;
    if ({d_req_ready, mem_rd, mem_wr} !== 3'b100) begin
      failures++;
      $display("FAIL oor_issue got rdy=%b rd=%b wr=%b exp 1 0 0", d_req_ready, mem_rd, mem_wr);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    checks++;
    if ({d_rsp_valid, d_rsp_err, d_rsp_data, mem_rd} !== {2'b11, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL oor_d_rsp got v=%b e=%b data=%h rd=%b exp v=1 e=1 data=0 rd=0",
               d_rsp_valid, d_rsp_err, d_rsp_data, mem_rd);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rsp_valid, if_rsp_err, if_rsp_data, d_rsp_valid} !== {2'b11, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL oor_if_rsp got v=%b e=%b data=%h dv=%b exp v=1 e=1 data=0 dv=0",
               if_rsp_valid, if_rsp_err, if_rsp_data, d_rsp_valid);
    end
    settle();
  endtask

  task automatic test_reset_drop();
    if_req_valid = 1'b1; if_req_addr = 32'd2;
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++; $display("FAIL drop_issue got rdy=%b exp 1", if_req_ready);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs !== '0) begin
      failures++; $display("FAIL drop_outputs_in_reset got=%h exp=0", all_outs);
    end
    @(negedge clk);
    #1 rst_n = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'd4;
    #1;
    checks++;
    if ({d_req_ready, mem_rd, if_rsp_valid} !== 3'b110) begin
      failures++;
      $display("FAIL first_edge_issue got rdy=%b rd=%b ifv=%b exp 1 1 0", d_req_ready, mem_rd, if_rsp_valid);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rsp_valid, d_rsp_valid, d_rsp_data} !== {2'b01, ref_mem[4]}) begin
      failures++;
      $display("FAIL drop_after_release got ifv=%b dv=%b data=%h exp ifv=0 dv=1 data=%h",
               if_rsp_valid, d_rsp_valid, d_rsp_data, ref_mem[4]);
    end
    @(negedge clk);
    checks++;
    if ({if_rsp_valid, d_rsp_valid} !== 2'b00) begin
      failures++; $display("FAIL drop_quiet got ifv=%b dv=%b exp 0 0", if_rsp_valid, d_rsp_valid);
    end
    settle();
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'hFFFF_FFFF;
    if (r == 1) return 32'(DEPTH + $urandom_range(0, 40));
    return 32'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic test_random(input int n);
    int          streak;
    logic        e_if_rsp, e_d_rsp, e_err, g_if, g_d, we, inr;
    logic [31:0] e_data, addr;
    streak = 0; e_if_rsp = 1'b0; e_d_rsp = 1'b0; e_err = 1'b0; e_data = '0;
    drive_idle();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checks++;
      if ({if_rsp_valid, if_rsp_err, if_rsp_data} !== {e_if_rsp, e_if_rsp & e_err, e_if_rsp ? e_data : 32'd0}) begin
        failures++;
        $display("FAIL rnd_if_rsp cyc=%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h", c,
                 if_rsp_valid, if_rsp_err, if_rsp_data, e_if_rsp, e_if_rsp & e_err, e_if_rsp ? e_data : 32'd0);
      end
      checks++;
      if ({d_rsp_valid, d_rsp_err, d_rsp_data} !== {e_d_rsp, e_d_rsp & e_err, e_d_rsp ? e_data : 32'd0}) begin
        failures++;
        $display("FAIL rnd_d_rsp cyc=%0d got v=%b e=%b d=%h exp v=%b e=%b d=%h", c,
                 d_rsp_valid, d_rsp_err, d_rsp_data, e_d_rsp, e_d_rsp & e_err, e_d_rsp ? e_data : 32'd0);
      end
      // Data wins unless it already took MAXS grants in a row with fetch waiting.
      g_d  = d_req_valid && !(if_req_valid && streak == MAXS);
      g_if = if_req_valid && !g_d;
      checks++;
      if ({if_req_ready, d_req_ready} !== {g_if, g_d}) begin
        failures++;
        $display("FAIL rnd_grant cyc=%0d got if=%b d=%b exp if=%b d=%b streak=%0d",
                 c, if_req_ready, d_req_ready, g_if, g_d, streak);
      end
      addr = g_if ? if_req_addr : d_req_addr;
      we   = g_d && d_req_we;
      inr  = (addr < DEPTH);
      checks++;
      if ({mem_rd, mem_wr} !== {(g_if | g_d) & inr & ~we, (g_if | g_d) & inr & we}) begin
        failures++;
        $display("FAIL rnd_strobe cyc=%0d got rd=%b wr=%b exp rd=%b wr=%b", c, mem_rd, mem_wr,
                 (g_if | g_d) & inr & ~we, (g_if | g_d) & inr & we);
      end
      if ((g_if | g_d) && inr) begin
        checks++;
        if (mem_addr !== addr || (we && mem_wdata !== d_req_wdata)) begin
          failures++;
          $display("FAIL rnd_mem_bus cyc=%0d got addr=%h wdata=%h exp addr=%h wdata=%h",
                   c, mem_addr, mem_wdata, addr, d_req_wdata);
        end
      end
      e_if_rsp = g_if; e_d_rsp = g_d; e_err = !inr;
      e_data = (!inr || we) ? 32'd0 : ref_mem[addr[AW-1:0]];
      if (we && inr) ref_mem[addr[AW-1:0]] = d_req_wdata;
      if (!if_req_valid || g_if) streak = 0;
      else if (g_d) streak++;
      @(posedge clk); #1;
      if (!if_req_valid || g_if) begin
        if_req_valid = ($urandom_range(0, 3) != 0);
        if_req_addr  = pick_addr();
      end
      if (!d_req_valid || g_d) begin
        d_req_valid = ($urandom_range(0, 3) != 0);
        d_req_we    = $urandom_range(0, 1) == 1;
        d_req_addr  = pick_addr();
        d_req_wdata = $urandom;
      end
    end
    settle();
  endtask

  initial begin
    drive_idle();
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      bd_we = 1'b1; bd_addr = AW'(i);
      bd_data = (i == 3) ? 32'h6661c213 : $urandom;
      ref_mem[i] = bd_data;
    end
    @(posedge clk); #1;
    bd_we = 1'b0;
    test_reset();
    test_fetch_single();
    test_conflict();
    test_back_to_back();
    test_out_of_range();
    test_reset_drop();
    test_random(400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose parameter DEPTH, default 16, meaning the number of valid word addresses in the attached memory.
REQ-002 The block SHALL expose parameter MAX_DSTREAK, default 2, meaning the maximum number of consecutive data grants while a fetch is pending.
REQ-003 The block SHALL expose the following ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req_valid  in  1  fetch read request.
- if_req_addr  in  32  fetch word address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  fetch response valid.
- if_rsp_data  out  32  fetch read data.
- if_rsp_err  out  1  fetch address out of range.
- d_req_valid  in  1  data request.
- d_req_we  in  1  1 = write, 0 = read.
- d_req_addr  in  32  data word address.
- d_req_wdata  in  32  write data.
- d_req_ready  out  1  data request accepted this cycle.
- d_rsp_valid  out  1  data response or write acknowledge.
- d_rsp_data  out  32  data read data.
- d_rsp_err  out  1  data address out of range.
- mem_addr  out  32  memory word address.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid one cycle after mem_rd.

Function
REQ-004 A requester SHALL hold valid, addr, we and wdata stable until it samples its ready high; ready SHALL be combinational and high only in the cycle that requester is issued.
REQ-005 At most one request SHALL be issued per cycle, and one SHALL be issued every cycle in which any valid is high (no bubbles).
REQ-006 When only one requester is valid, that requester SHALL be granted.
REQ-007 On conflict, the data port SHALL win unless the data streak counter equals MAX_DSTREAK, in which case fetch SHALL win.
REQ-008 The streak counter SHALL increment on each data grant made while fetch is valid, SHALL clear on any fetch grant, and SHALL clear on any cycle in which fetch is not valid.
REQ-009 An issued in-range read SHALL drive mem_rd = 1 and mem_addr = addr in the issue cycle; an issued in-range write SHALL drive mem_wr = 1, mem_addr = addr and mem_wdata = wdata in the issue cycle.
REQ-010 An address with addr >= DEPTH SHALL be issued with mem_rd = mem_wr = 0 and SHALL produce a response with rsp_err = 1 and rsp_data = 0.
REQ-011 Every issued request SHALL produce exactly one rsp_valid pulse on the owning port, exactly one cycle after issue. For a read, rsp_data SHALL equal mem_rdata; for a write, rsp_data SHALL be 0.
REQ-012 Response routing SHALL be tracked by a registered state with states RSP_NONE, RSP_IF and RSP_D, loaded each cycle from the current issue. No issue SHALL load RSP_NONE.
REQ-013 Responses SHALL have no backpressure, so back-to-back issue SHALL yield back-to-back responses.
REQ-014 A data write and a subsequent read to the same address issued in consecutive cycles SHALL return the written value.
REQ-015 rsp_data and rsp_err SHALL be 0 whenever the corresponding rsp_valid is 0.

Reset
REQ-016 While rst_n = 0, all outputs SHALL be 0, the response state SHALL be RSP_NONE, and the streak counter SHALL be 0, independent of clk.
REQ-017 A response pending when reset asserts SHALL be dropped and SHALL NOT appear after rst_n is released.
REQ-018 The first request SHALL be issuable on the first clk edge after rst_n is released.

Structure
REQ-019 Shared package riscv_mem_pkg SHALL hold the response-state enumeration, the DEPTH default and the 32-bit word width constant.
REQ-020 Grant selection, including the streak counter, SHALL be a sub-module named mem_grant_sel; response tracking and the memory mux SHALL stay in mem_arbiter.

Verification
REQ-021 Fetch only, addr 3, with memory word 3 = 0x6661c213 -> if_req_ready in cycle 0; if_rsp_valid in cycle 1 with data 0x6661c213 and err = 0.
REQ-022 Fetch and data read both held valid for 6 cycles -> grant order D, D, IF, D, D, IF.
REQ-023 Data write addr 5, data 0xDEADBEEF, then data read addr 5 on the next cycle -> d_rsp_valid on two consecutive cycles; second response data = 0xDEADBEEF.
REQ-024 Data read addr 16 -> mem_rd = 0 in the issue cycle; next cycle d_rsp_valid = 1, d_rsp_err = 1, data = 0.
REQ-025 Fetch issued, then rst_n pulsed low before the next edge -> no if_rsp_valid after release; all outputs 0 during reset.
